// File: rtl/axispktgen_pkg.sv
// Shared constants, FSM state type and helpers for the AXI-Stream packet generator.
package axispktgen_pkg;

  localparam logic [1:0] MODE_COUNT = 2'b00;
  localparam logic [1:0] MODE_CONST = 2'b01;
  localparam logic [1:0] MODE_LFSR  = 2'b10;

  // Fibonacci taps for x^32 + x^22 + x^2 + x + 1 (term x^n maps to bit n-1)
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED = 32'h0000_0001;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StGap
  } state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/lfsr32.sv
// 32-bit Fibonacci LFSR that steps once per cycle with advance high.
module lfsr32
  import axispktgen_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        advance,
  output logic [31:0] value
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= LFSR_SEED;
    end else if (advance) begin
      value <= {value[30:0], ^(value & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/axis_packet_generator.sv
// AXI-Stream packet generator: round-robin channel selection, programmable length,
// inter-packet gap and payload pattern (beat count, constant, LFSR).
module axis_packet_generator
  import axispktgen_pkg::*;
#(
  parameter int G_AXIS_DATA_WIDTH = 1024,
  parameter int G_NUM_CHANNELS    = 4,
  parameter int G_LEN_WIDTH       = 16,
  localparam int KEEP_W = G_AXIS_DATA_WIDTH / 8,
  localparam int DEST_W = (clog2(G_NUM_CHANNELS) < 1) ? 1 : clog2(G_NUM_CHANNELS)
) (
  input  logic                         axis_clk,
  input  logic                         axis_reset,
  input  logic                         enable,
  input  logic [G_LEN_WIDTH-1:0]       packet_length,
  input  logic [7:0]                   gap_cycles,
  input  logic [1:0]                   mode,
  input  logic [63:0]                  constant_pattern,
  input  logic [G_NUM_CHANNELS-1:0]    channel_mask,
  output logic [G_AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic [KEEP_W-1:0]            m_axis_tkeep,
  output logic                         m_axis_tlast,
  output logic [DEST_W-1:0]            m_axis_tdest,
  output logic [31:0]                  packet_count
);

  localparam logic [G_LEN_WIDTH-1:0] BYTES_L = G_LEN_WIDTH'(KEEP_W);

  state_e                      state_q;
  logic                        tvalid_q;
  logic [G_LEN_WIDTH-1:0]      beat_q;
  logic [G_LEN_WIDTH-1:0]      rem_q;
  logic [1:0]                  mode_q;
  logic [63:0]                 const_q;
  logic [DEST_W-1:0]           dest_q;
  logic [DEST_W-1:0]           rr_ptr_q;
  logic [DEST_W-1:0]           next_ch;
  logic [7:0]                  gap_q;
  logic [31:0]                 lfsr_value;
  logic [2*G_NUM_CHANNELS-1:0] mask_rot;
  logic [KEEP_W-1:0]           keep_last;
  logic                        start_ok;
  logic                        accept;
  logic                        last_beat;
  logic                        launch;

  assign start_ok  = enable && (packet_length != '0) && (channel_mask != '0);
  assign accept    = tvalid_q && m_axis_tready;
  // rem_q holds the bytes still to send, including the beat on the bus
  assign last_beat = (rem_q <= BYTES_L);

  // Doubled mask rotated so bit k is channel (ptr + 1 + k) mod N; lowest set bit wins.
  always_comb begin
    mask_rot = {channel_mask, channel_mask} >> (int'(rr_ptr_q) + 1);
    next_ch  = '0;
    for (int k = G_NUM_CHANNELS - 1; k >= 0; k--) begin
      if (mask_rot[k]) next_ch = DEST_W'((int'(rr_ptr_q) + 1 + k) % G_NUM_CHANNELS);
    end
  end

  always_comb begin
    launch = 1'b0;
    case (state_q)
      StIdle:  launch = start_ok;
      StSend:  launch = accept && last_beat && (gap_cycles == 8'd0) && start_ok;
      StGap:   launch = (gap_q <= 8'd1) && start_ok;
      default: launch = 1'b0;
    endcase
  end

  always_ff @(posedge axis_clk or posedge axis_reset) begin
    if (axis_reset) begin
      state_q      <= StIdle;
      tvalid_q     <= 1'b0;
      beat_q       <= '0;
      rem_q        <= '0;
      mode_q       <= MODE_COUNT;
      const_q      <= '0;
      dest_q       <= '0;
      rr_ptr_q     <= DEST_W'(G_NUM_CHANNELS - 1);
      gap_q        <= '0;
      packet_count <= '0;
    end else begin
      if (accept && last_beat) packet_count <= packet_count + 32'd1;
      if (launch) begin
        state_q  <= StSend;
        tvalid_q <= 1'b1;
        beat_q   <= '0;
        rem_q    <= packet_length;
        mode_q   <= ((mode == MODE_CONST) || (mode == MODE_LFSR)) ? mode : MODE_COUNT;
        const_q  <= constant_pattern;
        dest_q   <= next_ch;
        rr_ptr_q <= next_ch;
      end else begin
        case (state_q)
          StIdle: tvalid_q <= 1'b0;
          StSend: begin
            if (accept) begin
              if (last_beat) begin
                tvalid_q <= 1'b0;
                if (gap_cycles != 8'd0) begin
                  state_q <= StGap;
                  gap_q   <= gap_cycles;
                end else begin
                  state_q <= StIdle;
                end
              end else begin
                beat_q <= beat_q + G_LEN_WIDTH'(1);
                rem_q  <= rem_q - BYTES_L;
              end
            end
          end
          StGap: begin
            if (gap_q <= 8'd1) state_q <= StIdle;
            else gap_q <= gap_q - 8'd1;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  // The LFSR only steps on beats that actually carry LFSR payload
  lfsr32 u_lfsr (
    .clk     (axis_clk),
    .reset   (axis_reset),
    .advance (accept && (mode_q == MODE_LFSR)),
    .value   (lfsr_value)
  );

  always_comb begin
    for (int i = 0; i < KEEP_W; i++) begin
      keep_last[i] = (rem_q > G_LEN_WIDTH'(i));
    end
  end

  always_comb begin
    m_axis_tdata = '0;
    if (tvalid_q) begin
      case (mode_q)
        MODE_CONST: m_axis_tdata = {(G_AXIS_DATA_WIDTH / 64){const_q}};
        MODE_LFSR:  m_axis_tdata = {(G_AXIS_DATA_WIDTH / 32){lfsr_value}};
        default:    m_axis_tdata = G_AXIS_DATA_WIDTH'(beat_q);
      endcase
    end
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tvalid_q && last_beat;
  assign m_axis_tkeep  = !tvalid_q ? '0 : (last_beat ? keep_last : '1);
  assign m_axis_tdest  = dest_q;

endmodule

// File: tb/tb_axis_packet_generator.sv
// Directed bench for axis_packet_generator at DW=1024, four channels.
module tb_axis_packet_generator;

  localparam int DW = 1024;
  localparam int NC = 4;
  localparam int LW = 16;
  localparam int KB = DW / 8;

  logic          axis_clk = 1'b0;
  logic          axis_reset = 1'b1;
  logic          enable = 1'b0;
  logic [LW-1:0] packet_length = '0;
  logic [7:0]    gap_cycles = '0;
  logic [1:0]    mode = '0;
  logic [63:0]   constant_pattern = '0;
  logic [NC-1:0] channel_mask = '0;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic [KB-1:0] m_axis_tkeep;
  logic          m_axis_tlast;
  logic [1:0]    m_axis_tdest;
  logic [31:0]   packet_count;

  int            total = 0;
  int            bad = 0;
  logic [KB-1:0] ones_keep;
  logic [KB-1:0] keep44;
  logic [DW-1:0] const_rep;
  logic [31:0]   exp_lfsr;
  int            accepted;
  int            bip;

  axis_packet_generator #(
    .G_AXIS_DATA_WIDTH (DW),
    .G_NUM_CHANNELS    (NC),
    .G_LEN_WIDTH       (LW)
  ) dut (
    .axis_clk         (axis_clk),
    .axis_reset       (axis_reset),
    .enable           (enable),
    .packet_length    (packet_length),
    .gap_cycles       (gap_cycles),
    .mode             (mode),
    .constant_pattern (constant_pattern),
    .channel_mask     (channel_mask),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .m_axis_tkeep     (m_axis_tkeep),
    .m_axis_tlast     (m_axis_tlast),
    .m_axis_tdest     (m_axis_tdest),
    .packet_count     (packet_count)
  );

  always #5 axis_clk = ~axis_clk;

  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs[255:0], exp[255:0]);
    end
  endtask

  task automatic beat_chk(input string tag, input logic [DW-1:0] d, input logic [KB-1:0] k,
                          input logic l, input logic [1:0] dst);
    check({tag, "_valid"}, DW'(m_axis_tvalid), DW'(1'b1));
    check({tag, "_data"}, m_axis_tdata, d);
    check({tag, "_keep"}, DW'(m_axis_tkeep), DW'(k));
    check({tag, "_last"}, DW'(m_axis_tlast), DW'(l));
    check({tag, "_dest"}, DW'(m_axis_tdest), DW'(dst));
  endtask

  task automatic reset_chk(input string tag);
    check({tag, "_valid"}, DW'(m_axis_tvalid), '0);
    check({tag, "_last"}, DW'(m_axis_tlast), '0);
    check({tag, "_keep"}, DW'(m_axis_tkeep), '0);
    check({tag, "_data"}, m_axis_tdata, '0);
    check({tag, "_dest"}, DW'(m_axis_tdest), '0);
    check({tag, "_count"}, DW'(packet_count), '0);
  endtask

  initial begin
    ones_keep        = '1;
    keep44           = '0;
    keep44[43:0]     = '1;
    constant_pattern = 64'hDEAD_BEEF_CAFE_F00D;
    const_rep        = {16{64'hDEAD_BEEF_CAFE_F00D}};

    // Reset state, then beat-count mode: len 1024 -> 8 full beats, back to back
    packet_length = 16'd1024;
    channel_mask  = 4'b0001;
    repeat (2) @(negedge axis_clk);
    reset_chk("rst");
    axis_reset = 1'b0;
    enable     = 1'b1;
    for (int b = 0; b < 16; b++) begin
      @(negedge axis_clk);
      beat_chk("t1", DW'(b % 8), ones_keep, (b % 8) == 7, 2'd0);
    end
    enable = 1'b0;
    @(negedge axis_clk);
    check("t1_idle", DW'(m_axis_tvalid), '0);
    check("t1_count", DW'(packet_count), DW'(2));

    // Constant mode, len 300 -> 128+128+44 bytes, 3-cycle gap
    mode          = 2'b01;
    packet_length = 16'd300;
    gap_cycles    = 8'd3;
    enable        = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(negedge axis_clk);
      if ((c % 6) < 3) beat_chk("t2", const_rep, ((c % 6) == 2) ? keep44 : ones_keep,
                                (c % 6) == 2, 2'd0);
      else check("t2_gap", DW'(m_axis_tvalid), '0);
    end
    enable = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge axis_clk);
      check("t2_idle", DW'(m_axis_tvalid), '0);
    end
    check("t2_count", DW'(packet_count), DW'(4));

    // Round robin over mask 1010 with single-beat packets, then empty mask
    mode          = 2'b00;
    packet_length = 16'd128;
    gap_cycles    = 8'd0;
    channel_mask  = 4'b1010;
    enable        = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge axis_clk);
      beat_chk("t3", '0, ones_keep, 1'b1, (i % 2 == 0) ? 2'd1 : 2'd3);
    end
    channel_mask = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge axis_clk);
      check("t3_nomask", DW'(m_axis_tvalid), '0);
    end
    check("t3_count", DW'(packet_count), DW'(8));
    enable = 1'b0;

    // Enable drop on beat 2; length/mode changes must not disturb the packet
    channel_mask  = 4'b0001;
    packet_length = 16'd1024;
    enable        = 1'b1;
    for (int b = 0; b < 8; b++) begin
      @(negedge axis_clk);
      beat_chk("t4", DW'(b), ones_keep, b == 7, 2'd0);
      if (b == 2) begin
        enable        = 1'b0;
        packet_length = 16'd10;
        mode          = 2'b01;
      end
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge axis_clk);
      check("t4_idle", DW'(m_axis_tvalid), '0);
    end
    check("t4_count", DW'(packet_count), DW'(9));

    // Reset mid-packet: channel 1 in flight, restart on channel 0 at beat 0
    mode          = 2'b00;
    packet_length = 16'd1024;
    channel_mask  = 4'b0011;
    enable        = 1'b1;
    for (int b = 0; b < 4; b++) begin
      @(negedge axis_clk);
      beat_chk("t5", DW'(b), ones_keep, 1'b0, 2'd1);
    end
    axis_reset = 1'b1;
    #1;
    reset_chk("t5_rst");
    @(negedge axis_clk);
    axis_reset = 1'b0;
    @(negedge axis_clk);
    beat_chk("t5_restart", '0, ones_keep, 1'b0, 2'd0);
    enable = 1'b0;
    repeat (8) @(negedge axis_clk);
    check("t5_idle", DW'(m_axis_tvalid), '0);
    check("t5_count", DW'(packet_count), DW'(1));

    // LFSR mode under random backpressure: 3 packets of 3 beats, gap 1
    mode          = 2'b10;
    packet_length = 16'd384;
    gap_cycles    = 8'd1;
    channel_mask  = 4'b0001;
    enable        = 1'b1;
    m_axis_tready = 1'b0;
    exp_lfsr      = 32'h0000_0001;
    accepted      = 0;
    bip           = 0;
    for (int c = 0; c < 400 && accepted < 9; c++) begin
      @(negedge axis_clk);
      if (m_axis_tvalid) begin
        check("t6_data", m_axis_tdata, {32{exp_lfsr}});
        check("t6_last", DW'(m_axis_tlast), DW'(bip == 2));
        if (accepted == 6) enable = 1'b0;
        m_axis_tready = 1'($urandom_range(1));
        if (m_axis_tready) begin
          exp_lfsr = lfsr_next(exp_lfsr);
          accepted++;
          bip = (bip + 1) % 3;
        end
      end else begin
        m_axis_tready = 1'($urandom_range(1));
      end
    end
    check("t6_accepted", DW'(accepted), DW'(9));
    m_axis_tready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge axis_clk);
      check("t6_idle", DW'(m_axis_tvalid), '0);
    end
    check("t6_count", DW'(packet_count), DW'(4));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
